// File: rtl/rand_range_sampler.sv
// Draws an unbiased value in [0,N) from an upstream LFSR by mask-and-reject sampling,
// with a bounded retry count and a subtract-N fallback once the retries run out.
`timescale 1ns/1ps
module rand_range_sampler #(
  parameter int unsigned RandWidth  = 16,
  parameter int unsigned OutWidth   = 8,
  parameter int unsigned MaxRetries = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [RandWidth-1:0] rand_i,
  output logic                 rand_en_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [OutWidth-1:0]  bound_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [OutWidth-1:0]  rsp_data_o,
  output logic                 rsp_fallback_o,
  output logic [15:0]          fallback_cnt_o
);

  typedef enum logic [1:0] {StIdle, StSample, StResp} state_e;

  localparam logic [7:0] LastAttempt = 8'(MaxRetries - 1);

  state_e              state_q, state_d;
  logic [OutWidth-1:0] bound_q, bound_d;
  logic [OutWidth-1:0] mask_q, mask_d;
  logic [OutWidth-1:0] data_q, data_d;
  logic                fallback_q, fallback_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [7:0]          attempt_q, attempt_d;

  logic [OutWidth-1:0] req_mask;
  logic [OutWidth-1:0] cand;
  logic                hit;
  logic                last_attempt;
  logic                unused_rand;

  assign unused_rand = ^rand_i;

  // Smear the highest set bit of N-1 downwards to get the smallest 2^k-1 covering it.
  always_comb begin
    req_mask = bound_i - 1'b1;
    for (int i = 0; i < int'(OutWidth); i++) begin
      req_mask = req_mask | (req_mask >> 1);
    end
    if (bound_i == '0) begin
      req_mask = '1;
    end
  end

  assign cand         = rand_i[OutWidth-1:0] & mask_q;
  assign hit          = (bound_q == '0) || (cand < bound_q);
  assign last_attempt = (attempt_q == LastAttempt);

  // State register and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bound_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      fallback_q <= 1'b0;
      fcnt_q     <= '0;
      attempt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bound_q    <= bound_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      fallback_q <= fallback_d;
      fcnt_q     <= fcnt_d;
      attempt_q  <= attempt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    bound_d    = bound_q;
    mask_d     = mask_q;
    data_d     = data_q;
    fallback_d = fallback_q;
    fcnt_d     = fcnt_q;
    attempt_d  = attempt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          bound_d   = bound_i;
          mask_d    = req_mask;
          attempt_d = '0;
          state_d   = StSample;
        end
      end
      StSample: begin
        if (hit) begin
          data_d     = cand;
          fallback_d = 1'b0;
          state_d    = StResp;
        end else if (last_attempt) begin
          // mask < 2N, so cand - N is already inside [0,N)
          data_d     = cand - bound_q;
          fallback_d = 1'b1;
          if (fcnt_q != 16'hFFFF) begin
            fcnt_d = fcnt_q + 16'd1;
          end
          state_d    = StResp;
        end else begin
          attempt_d = attempt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o = 1'b0;
    rand_en_o   = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      StIdle:   req_ready_o = 1'b1;
      StSample: rand_en_o   = 1'b1;
      StResp:   rsp_valid_o = 1'b1;
      default:  req_ready_o = 1'b0;
    endcase
  end

  assign rsp_data_o     = data_q;
  assign rsp_fallback_o = fallback_q;
  assign fallback_cnt_o = fcnt_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: directed scenarios with literal expectations plus a
// randomized run against a transaction-level model fed by a 16-bit LFSR.
`timescale 1ns/1ps
module tb_rand_range_sampler;

  localparam int unsigned RandWidth  = 16;
  localparam int unsigned OutWidth   = 8;
  localparam int unsigned MaxRetries = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rand_i;
  logic        rand_en_o;
  logic        req_valid;
  logic        req_ready_o;
  logic [7:0]  bound;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [7:0]  rsp_data_o;
  logic        rsp_fb_o;
  logic [15:0] fcnt_o;

  logic        use_lfsr;
  logic [15:0] lfsr;
  logic [15:0] rand_drv;
  logic [15:0] wq [4];

  int n_chk = 0;
  int n_fail = 0;

  assign rand_i = use_lfsr ? lfsr : rand_drv;

  always #5 clk = ~clk;

  rand_range_sampler #(
    .RandWidth (RandWidth),
    .OutWidth  (OutWidth),
    .MaxRetries(MaxRetries)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rand_i        (rand_i),
    .rand_en_o     (rand_en_o),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .bound_i       (bound),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data_o),
    .rsp_fallback_o(rsp_fb_o),
    .fallback_cnt_o(fcnt_o)
  );

  // Upstream LFSR, steps only when asked
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else if (rand_en_o) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int dut_pulses = 0;
  always @(posedge clk) if (rand_en_o) dut_pulses <= dut_pulses + 1;

  // Transaction model: phase 0 waiting, 1 drawing, 2 holding a result
  int          m_phase;
  int          m_n, m_mask, m_att, m_data, m_fb, m_fcnt, m_resps;
  int          m_pulses = 0;

  function automatic int mask_of(input int n);
    int m = 0;
    if (n == 0) return 255;
    while (m < n - 1) m = m * 2 + 1;
    return m;
  endfunction

  function automatic int cand_of(input logic [15:0] r, input int mask);
    return int'(r[7:0]) & mask;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_n <= 0; m_mask <= 0; m_att <= 0;
      m_data <= 0; m_fb <= 0; m_fcnt <= 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_n <= int'(bound); m_mask <= mask_of(int'(bound)); m_att <= 0; m_phase <= 1;
        end
        1: begin
          m_pulses <= m_pulses + 1;
          m_att    <= m_att + 1;
          if (m_n == 0 || cand_of(rand_i, m_mask) < m_n) begin
            m_data <= cand_of(rand_i, m_mask); m_fb <= 0; m_phase <= 2;
          end else if (m_att + 1 == int'(MaxRetries)) begin
            m_data <= cand_of(rand_i, m_mask) - m_n; m_fb <= 1; m_phase <= 2;
            if (m_fcnt != 65535) m_fcnt <= m_fcnt + 1;
          end
        end
        default: if (rsp_ready) begin m_phase <= 0; m_resps <= m_resps + 1; end
      endcase
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("req_ready", longint'(req_ready_o), longint'(m_phase == 0));
    chk("rand_en", longint'(rand_en_o), longint'(m_phase == 1));
    chk("rsp_valid", longint'(rsp_valid_o), longint'(m_phase == 2));
    chk("fallback_cnt", longint'(fcnt_o), longint'(m_fcnt));
    if (m_phase == 2) begin
      chk("rsp_data", longint'(rsp_data_o), longint'(m_data));
      chk("rsp_fallback", longint'(rsp_fb_o), longint'(m_fb));
      if (m_n != 0) chk("rsp_in_range", longint'(int'(rsp_data_o) < m_n), 1);
    end
  endtask

  // Every cycle: compare at the falling edge, then return #1 after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (!rst) check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [7:0] n, input int nw, output int data, output int fb,
                         output int lat, output int pulses);
    int p0;
    int guard;
    p0 = dut_pulses;
    req_valid = 1'b1;
    bound = n;
    guard = 0;
    while (!req_ready_o && guard < 20) begin tick(); guard++; end
    tick();
    req_valid = 1'b0;
    bound = 8'($urandom);
    lat = 1;
    rand_drv = wq[0];
    while (!rsp_valid_o && lat < int'(MaxRetries) + 5) begin
      tick();
      lat++;
      if (!rsp_valid_o) rand_drv = wq[(lat - 1 < nw) ? lat - 1 : nw - 1];
    end
    data = int'(rsp_data_o);
    fb = int'(rsp_fb_o);
    pulses = dut_pulses - p0;
    if (rsp_ready) tick();
  endtask

  initial begin
    int d, f, l, p, hold;
    rst = 1'b0; use_lfsr = 1'b0; rand_drv = '0;
    req_valid = 1'b0; bound = '0; rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset_rsp_valid", longint'(rsp_valid_o), 0);
    chk("reset_rand_en", longint'(rand_en_o), 0);
    chk("reset_data", longint'(rsp_data_o), 0);
    chk("reset_fallback", longint'(rsp_fb_o), 0);
    chk("reset_fcnt", longint'(fcnt_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_req_ready", longint'(req_ready_o), 1);
    tick();

    // Two rejects then accept
    wq[0] = 16'h000C; wq[1] = 16'h003D; wq[2] = 16'h0007; wq[3] = 16'h0007;
    run_req(8'd10, 3, d, f, l, p);
    chk("s1_data", d, 7); chk("s1_fb", f, 0); chk("s1_lat", l, 4); chk("s1_pulses", p, 3);

    // Retries exhausted -> fallback
    chk("s2_fcnt_before", longint'(fcnt_o), 0);
    wq[0] = 16'h0006; wq[1] = 16'h0006; wq[2] = 16'h0006; wq[3] = 16'h0006;
    run_req(8'd5, 4, d, f, l, p);
    chk("s2_data", d, 1); chk("s2_fb", f, 1); chk("s2_lat", l, 5); chk("s2_pulses", p, 4);
    chk("s2_fcnt_after", longint'(fcnt_o), 1);

    // Full range and N=1
    wq[0] = 16'h01AB;
    run_req(8'd0, 1, d, f, l, p);
    chk("s3_full_data", d, 'hAB); chk("s3_full_lat", l, 2); chk("s3_full_pulses", p, 1);
    wq[0] = 16'h00FF;
    run_req(8'd1, 1, d, f, l, p);
    chk("s3_one_data", d, 0); chk("s3_one_fb", f, 0); chk("s3_one_lat", l, 2);

    // Consumer stalls in RESP
    rsp_ready = 1'b0;
    wq[0] = 16'h0055;
    run_req(8'd200, 1, d, f, l, p);
    chk("s4_data", d, 'h55);
    req_valid = 1'b1; bound = 8'd200;
    hold = 0;
    repeat (5) begin
      chk("s4_hold_data", longint'(rsp_data_o), 'h55);
      chk("s4_hold_rand_en", longint'(rand_en_o), 0);
      chk("s4_hold_req_ready", longint'(req_ready_o), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("s4_bubble_valid", longint'(rsp_valid_o), 0);
    chk("s4_bubble_ready", longint'(req_ready_o), 1);
    tick();
    req_valid = 1'b0;
    chk("s4_next_accepted", longint'(rand_en_o), 1);
    while (!rsp_valid_o && hold < 10) begin tick(); hold++; end
    chk("s4_next_done", longint'(rsp_valid_o), 1);
    tick();

    // Reset in the second SAMPLE cycle aborts the request
    wq[0] = 16'h0006;
    req_valid = 1'b1; bound = 8'd5;
    tick();
    req_valid = 1'b0;
    rand_drv = 16'h0006;
    tick();
    chk("s5_in_sample", longint'(rand_en_o), 1);
    rst = 1'b1;
    #1;
    chk("s5_rand_en", longint'(rand_en_o), 0);
    chk("s5_rsp_valid", longint'(rsp_valid_o), 0);
    chk("s5_fcnt", longint'(fcnt_o), 0);
    chk("s5_data", longint'(rsp_data_o), 0);
    #1 rst = 1'b0;
    repeat (6) begin
      tick();
      chk("s5_no_rsp", longint'(rsp_valid_o), 0);
    end

    // Randomized traffic from the LFSR
    use_lfsr = 1'b1;
    m_resps = 0;
    repeat (4000) begin
      req_valid = ($urandom % 3) != 0;
      bound = ($urandom % 4 == 0) ? 8'($urandom % 4) : 8'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) tick();
    chk("rand_pulse_total", dut_pulses, m_pulses);
    chk("rand_enough_rsps", longint'(m_resps > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
